// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO read port onto a framed
// valid/ready stream, using a 2-entry buffer to hide the FIFO read latency.
module fifo_stream_reader #(
  parameter int SIZE_DATA = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [SIZE_DATA-1:0] o_m_data,
  output logic                 o_m_last,
  output logic [CNT_WIDTH-1:0] o_pkt_count,
  output logic                 o_busy
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [SIZE_DATA-1:0] head_q, head_d;
  logic [SIZE_DATA-1:0] tail_q, tail_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 pop_s;
  logic                 rd_en_s;
  logic [2:0]           pending_s;

  // Words that will still be held after this cycle's pop decide whether a new read fits.
  always_comb begin
    pop_s     = valid_q & i_m_ready;
    pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s   = i_enable & ~i_fifo_empty & (pending_s <= 3'd1);
  end

  // Two-entry ordered buffer: capture of the in-flight word and pop may coincide.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({inflight_q, pop_s})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_d = i_fifo_data;
        end else begin
          tail_d = i_fifo_data;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = i_fifo_data;
        end else begin
          head_d = i_fifo_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Packet framing: beat position survives enable gaps, only reset clears it.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (pop_s) begin
      if (beat_q == BEAT_LAST) begin
        beat_d = {BEAT_W{1'b0}};
        pkt_d  = pkt_q + CNT_WIDTH'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      beat_d = beat_q;
      pkt_d  = pkt_q;
    end
  end

  // Output flags are computed from next state so they can be registered.
  always_comb begin
    inflight_d = rd_en_s;
    valid_d    = (occ_d != 2'd0);
    last_d     = valid_d & (beat_d == BEAT_LAST);
    busy_d     = inflight_d | (occ_d != 2'd0);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= {SIZE_DATA{1'b0}};
      tail_q     <= {SIZE_DATA{1'b0}};
      beat_q     <= {BEAT_W{1'b0}};
      pkt_q      <= {CNT_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign o_fifo_rd_en = rd_en_s;
  assign o_m_valid    = valid_q;
  assign o_m_data     = head_q;
  assign o_m_last     = last_q;
  assign o_pkt_count  = pkt_q;
  assign o_busy       = busy_q;

endmodule
